fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues reads to the synchronous program ROM. Returned instruction words are buffered, together with their PC, in a small prefetch queue. Decode consumes them over a valid/ready handshake. The block also supports a branch/jump redirect that flushes the queue, and a HALT opcode that stops fetching.

## Interface
Parameters:
- ADDR_W, 5, PC / ROM address width (32-word program space)
- DATA_W, 32, instruction width; opcode = bits [DATA_W-1:DATA_W-5]
- DEPTH, 4, prefetch queue entries (power of 2, ≥2)
- HALT_OP, 5'b11111, opcode that stops fetching

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_req  out  1  ROM read strobe (combinational from state)
- imem_addr  out  ADDR_W  ROM address; equals pc
- imem_data  in  DATA_W  ROM read data; valid the cycle after imem_req
- redirect_valid  in  1  load new PC and flush
- redirect_pc  in  ADDR_W  target PC
- ir_valid  out  1  queue head valid for decode
- ir  out  DATA_W  head instruction word
- ir_pc  out  ADDR_W  PC of head word
- ir_ready  in  1  decode accepts head this cycle
- halted  out  1  HALT word captured; fetching stopped
- count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
State:
- pc
- inflight bit plus inflight_pc
- circular queue: head/tail pointers and count
- halted

Request:
- imem_req = !reset && !halted && !redirect_valid && (count + inflight) < DEPTH.
- imem_addr = pc.
- On request: pc <= pc+1 (mod 2^ADDR_W, 31 wraps to 0); inflight <= 1; inflight_pc <= pc.
- Otherwise inflight <= 0.

Response:
- If inflight && !redirect_valid, push {imem_data, inflight_pc} at tail.
- If the pushed word's opcode == HALT_OP, set halted <= 1. The HALT word itself is still queued and delivered.

Dequeue:
- ir_valid = (count != 0) && !redirect_valid.
- ir / ir_pc show the head entry.
- Handshake (ir_valid && ir_ready) pops the head.
- A push and a pop in the same cycle leave count unchanged.

Redirect (highest priority after reset):
- pc <= redirect_pc; count, head and tail <= 0; inflight <= 0; halted <= 0.
- The response arriving this cycle is discarded.
- No request is issued and no pop occurs.

Reset:
- pc=0, count=0, inflight=0, halted=0, head=tail=0.
- Outputs: imem_req=0 during the reset cycle; ir_valid=0; ir=0; ir_pc=0; halted=0; count=0.
- Reset mid-operation discards all queued and in-flight words.

Queue invariant: count + inflight ≤ DEPTH always, so overflow is impossible. Popping when empty cannot occur because ir_valid=0.

## Timing
- Cycle 0 after reset release: imem_req=1, imem_addr=0.
- Cycle 1: data for PC 0 is pushed; request for PC 1 is issued.
- Cycle 2: ir_valid=1, ir_pc=0.
- Fetch-to-decode latency is 2 cycles. Throughput is 1 word/cycle with ir_ready held high.
- Redirect in cycle N: first request at redirect_pc in N+1; that word is presented in N+3.
- HALT pushed in cycle N: halted=1 from N+1; no imem_req from N+1 on. One request may have been issued in cycle N; its response is dropped if halted was set.
- Backpressure: with ir_ready=0, requests stop once count + inflight = DEPTH. Requests resume the cycle after the first pop frees space.
- All outputs except imem_req, imem_addr and ir_valid are registered. ir_valid is gated combinationally by redirect_valid.

## Test plan
- Reset then ir_ready=1, ROM[k]=k: ir = 0,1,2,… with ir_pc = 0,1,2,…, first valid 2 cycles after reset release, one word per cycle, no gaps.
- Backpressure: ir_ready=0 from reset → exactly 4 imem_req pulses (addr 0–3), count reaches 4, imem_req stays 0. Release ir_ready → words 0,1,2,3,4,… in order, no loss or duplication.
- Redirect to 20 with 3 words queued and one in flight: ir_valid=0 in the redirect cycle, count=0 the next cycle, next delivered word has ir_pc=20 three cycles after the redirect, no stale PC delivered.
- Halt: ROM[3]={5'b11111,27'b0} → words 0–3 delivered, halted=1, no imem_req afterwards. Redirect to 0 clears halted and fetching restarts at 0.
- Wrap: redirect to 30 → ir_pc sequence 30, 31, 0, 1.
- Reset asserted with a full queue and a request in flight: next cycle count=0, ir_valid=0, halted=0. After release, ir_pc=0 is delivered first.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-to-memory/decode bus: ROM read port, redirect input, decode handshake and status.
// master = fetch unit side, slave = ROM / decode / control side.
interface fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;
    logic              halted;
    logic [CNT_W-1:0]  count;

    modport master (
        output imem_req, imem_addr,
        input  imem_data,
        input  redirect_valid, redirect_pc,
        output ir_valid, ir, ir_pc,
        input  ir_ready,
        output halted, count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_data,
        output redirect_valid, redirect_pc,
        input  ir_valid, ir, ir_pc,
        output ir_ready,
        input  halted, count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a synchronous ROM and buffers {word, pc} in a prefetch queue.
// Latency 2 cycles request-to-decode; requests stop when queue plus in-flight word would exceed DEPTH.
// Backpressure: ir_ready low holds the head; redirect flushes everything and HALT stops fetching.
module fetch_unit #(
    parameter int         ADDR_W  = 5,
    parameter int         DATA_W  = 32,
    parameter int         DEPTH   = 4,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            q_mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              halted_q;

    logic              req;
    logic              push;
    logic              push_halt;
    logic              pop;
    logic              ir_vld;
    logic [CNT_W:0]    occupancy;

    always_comb begin
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
        req       = !reset && !halted_q && !bus.redirect_valid
                    && (occupancy < (CNT_W+1)'(DEPTH));
        // A response landing after HALT was captured is the one speculative fetch; drop it.
        push      = inflight && !bus.redirect_valid && !halted_q;
        push_halt = push && (bus.imem_data[DATA_W-1 -: 5] == HALT_OP);
        ir_vld    = (count_q != '0) && !bus.redirect_valid;
        pop       = ir_vld && bus.ir_ready;
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.ir_valid  = ir_vld;
    assign bus.ir        = q_mem[head].dat;
    assign bus.ir_pc     = q_mem[head].pc;
    assign bus.halted    = halted_q;
    assign bus.count     = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            halted_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            inflight <= req;
            if (req) begin
                pc          <= pc + 1'b1;
                inflight_pc <= pc;
            end
            if (push) begin
                q_mem[tail] <= '{dat: bus.imem_data, pc: inflight_pc};
                tail        <= tail + 1'b1;
                if (push_halt) begin
                    halted_q <= 1'b1;
                end
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a program-order stream model.
module tb_fetch_unit;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .HALT_OP(5'b11111)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [DATA_W-1:0] rom [32];
    always @(posedge clock) begin
        if (bus.imem_req) bus.imem_data <= rom[bus.imem_addr];
    end

    int errors = 0;
    int checks = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic rdy);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready = rdy;
        tick();
        reset = 1'b0;
    endtask

    task automatic rom_seq();
        for (int k = 0; k < 32; k++) rom[k] = 32'(k);
    endtask

    task automatic rom_random();
        logic [31:0] w;
        for (int k = 0; k < 32; k++) begin
            w = $urandom;
            if (w[31:27] == 5'b11111) w[31] = 1'b0;
            rom[k] = w;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready = 1'b0;
        tick();
        @(negedge clock);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0b want 0", bus.imem_req); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %0b want 0", bus.ir_valid); end
        checks++; if (bus.ir !== '0) begin errors++; $display("FAIL reset_ir: got %h want 0", bus.ir); end
        checks++; if (bus.ir_pc !== '0) begin errors++; $display("FAIL reset_ir_pc: got %0d want 0", bus.ir_pc); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_stream();
        logic [ADDR_W-1:0] exp_pc;
        logic exp_v;
        rom_seq();
        start(1'b1);
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clock);
            if (cyc == 0) begin
                checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %0b want 1", bus.imem_req); end
                checks++; if (bus.imem_addr !== '0) begin errors++; $display("FAIL stream_first_addr: got %0d want 0", bus.imem_addr); end
            end
            exp_v = (cyc >= 2);
            checks++;
            if (bus.ir_valid !== exp_v) begin errors++; $display("FAIL stream_valid cyc%0d: got %0b want %0b", cyc, bus.ir_valid, exp_v); end
            if (exp_v) begin
                exp_pc = ADDR_W'(cyc - 2);
                checks++; if (bus.ir_pc !== exp_pc) begin errors++; $display("FAIL stream_pc cyc%0d: got %0d want %0d", cyc, bus.ir_pc, exp_pc); end
                checks++; if (bus.ir !== rom[exp_pc]) begin errors++; $display("FAIL stream_ir cyc%0d: got %h want %h", cyc, bus.ir, rom[exp_pc]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        int ndel = 0;
        logic [ADDR_W-1:0] exp_pc = '0;
        rom_seq();
        start(1'b0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            if (bus.imem_req === 1'b1) begin
                checks++; if (bus.imem_addr !== ADDR_W'(nreq)) begin errors++; $display("FAIL bp_req_addr: got %0d want %0d", bus.imem_addr, nreq); end
                nreq++;
            end
            tick();
        end
        @(negedge clock);
        checks++; if (nreq != 4) begin errors++; $display("FAIL bp_req_pulses: got %0d want 4", nreq); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d want 4", bus.count); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stopped: got %0b want 0", bus.imem_req); end
        tick();
        bus.ir_ready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clock);
            if (bus.ir_valid === 1'b1) begin
                checks++; if (bus.ir_pc !== exp_pc) begin errors++; $display("FAIL bp_order_pc: got %0d want %0d", bus.ir_pc, exp_pc); end
                checks++; if (bus.ir !== rom[exp_pc]) begin errors++; $display("FAIL bp_order_ir: got %h want %h", bus.ir, rom[exp_pc]); end
                exp_pc++;
                ndel++;
            end
            tick();
        end
        checks++; if (ndel < 12) begin errors++; $display("FAIL bp_drain_rate: got %0d words want >=12", ndel); end
    endtask

    task automatic test_redirect();
        logic [ADDR_W-1:0] exp_pc;
        rom_random();
        start(1'b0);
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 5'd20;
        bus.ir_ready = 1'b1;
        @(negedge clock);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL redir_pre_count: got %0d want 3", bus.count); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_gate: got %0b want 0", bus.ir_valid); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %0b want 0", bus.imem_req); end
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clock);
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL redir_flush_count: got %0d want 0", bus.count); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd20) begin errors++; $display("FAIL redir_new_req: got req=%0b addr=%0d want req=1 addr=20", bus.imem_req, bus.imem_addr); end
        tick();
        @(negedge clock);
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL redir_n2_valid: got %0b want 0", bus.ir_valid); end
        tick();
        exp_pc = 5'd20;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clock);
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_pc !== exp_pc || bus.ir !== rom[exp_pc]) begin
                errors++;
                $display("FAIL redir_stream: got v=%0b pc=%0d ir=%h want v=1 pc=%0d ir=%h", bus.ir_valid, bus.ir_pc, bus.ir, exp_pc, rom[exp_pc]);
            end
            exp_pc++;
            tick();
        end
    endtask

    task automatic test_halt();
        int ndel = 0;
        logic [ADDR_W-1:0] exp_pc = '0;
        rom_seq();
        rom[3] = {5'b11111, 27'b0};
        start(1'b1);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            if (bus.ir_valid === 1'b1) begin
                checks++;
                if (ndel >= 4 || bus.ir_pc !== exp_pc || bus.ir !== rom[exp_pc]) begin
                    errors++;
                    $display("FAIL halt_delivery: got pc=%0d ir=%h want pc=%0d (words 0-3 only)", bus.ir_pc, bus.ir, exp_pc);
                end
                exp_pc++;
                ndel++;
            end
            if (bus.halted === 1'b1 && bus.imem_req !== 1'b0) begin
                checks++; errors++;
                $display("FAIL halt_req_after: got imem_req=%0b want 0", bus.imem_req);
            end
            tick();
        end
        checks++; if (ndel != 4) begin errors++; $display("FAIL halt_count_words: got %0d want 4", ndel); end
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %0b want 1", bus.halted); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = '0;
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clock);
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %0b want 0", bus.halted); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== '0) begin errors++; $display("FAIL halt_restart: got req=%0b addr=%0d want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        tick();
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_pc = 5'd30;
        int ndel = 0;
        rom_random();
        start(1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 5'd30;
        tick();
        bus.redirect_valid = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clock);
            if (bus.ir_valid === 1'b1) begin
                checks++;
                if (bus.ir_pc !== exp_pc || bus.ir !== rom[exp_pc]) begin
                    errors++;
                    $display("FAIL wrap_pc: got pc=%0d ir=%h want pc=%0d ir=%h", bus.ir_pc, bus.ir, exp_pc, rom[exp_pc]);
                end
                exp_pc++;
                ndel++;
            end
            tick();
        end
        checks++; if (ndel < 4) begin errors++; $display("FAIL wrap_words: got %0d want >=4", ndel); end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        rom_random();
        start(1'b0);
        repeat (4) tick();
        @(negedge clock);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: got %0d want 3", bus.count); end
        reset = 1'b1;
        tick();
        @(negedge clock);
        checks++; if (bus.count !== '0) begin errors++; $display("FAIL rmid_count: got %0d want 0", bus.count); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", bus.ir_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rmid_halted: got %0b want 0", bus.halted); end
        tick();
        reset = 1'b0;
        bus.ir_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && first < 0; cyc++) begin
            @(negedge clock);
            if (bus.ir_valid === 1'b1) begin
                first = cyc;
                checks++; if (bus.ir_pc !== '0) begin errors++; $display("FAIL rmid_first_pc: got %0d want 0", bus.ir_pc); end
            end
            tick();
        end
        checks++; if (first != 2) begin errors++; $display("FAIL rmid_first_cycle: got %0d want 2", first); end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] exp_pc = '0;
        logic done = 1'b0;
        int stall = 0;
        int ndel = 0;
        rom_random();
        for (int h = 0; h < 3; h++) rom[$urandom_range(0, 31)] = {5'b11111, 27'($urandom)};
        start(1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.ir_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = ADDR_W'($urandom);
            @(negedge clock);
            if (bus.redirect_valid) begin
                checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_valid cyc%0d: got %0b want 0", cyc, bus.ir_valid); end
                exp_pc = bus.redirect_pc;
                done = 1'b0;
                stall = 0;
            end else if (bus.ir_valid === 1'b1 && bus.ir_ready) begin
                checks++;
                if (done || bus.ir_pc !== exp_pc || bus.ir !== rom[exp_pc]) begin
                    errors++;
                    $display("FAIL rnd_word cyc%0d: got pc=%0d ir=%h want pc=%0d ir=%h done=%0b", cyc, bus.ir_pc, bus.ir, exp_pc, rom[exp_pc], done);
                end
                if (rom[exp_pc][31:27] == 5'b11111) done = 1'b1;
                exp_pc++;
                stall = 0;
                ndel++;
            end else if (!done) begin
                stall++;
                if (stall == 30) begin
                    checks++; errors++;
                    $display("FAIL rnd_stall cyc%0d: got no word for 30 cycles want progress", cyc);
                end
            end
            checks++; if (bus.count > 3'd4) begin errors++; $display("FAIL rnd_count cyc%0d: got %0d want <=4", cyc, bus.count); end
            if (bus.halted === 1'b1 && bus.imem_req !== 1'b0) begin
                checks++; errors++;
                $display("FAIL rnd_req_halted cyc%0d: got imem_req=%0b want 0", cyc, bus.imem_req);
            end
            tick();
        end
        bus.redirect_valid = 1'b0;
        checks++; if (ndel < 500) begin errors++; $display("FAIL rnd_throughput: got %0d words want >=500", ndel); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
